regfile_param: RTL
==================

# regfile_param

Parametrised register file with a write-pending scoreboard, the next-generation general-purpose register bank for the datapath. It replaces fixed 32×32 storage and external one-hot write-enable gating with an internal binary write decoder. It provides configurable width and depth, two asynchronous read ports and an optional hard-wired zero register. Per-register busy bits let the issue stage detect read-after-write hazards on results that have not yet been written back.

## Interface
- WIDTH, 32, data width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W registers
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and never goes busy; 0: register 0 is ordinary
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all registers and busy bits
- we  input  1  write enable for write-back port
- waddr  input  ADDR_W  write-back register index
- wdata  input  WIDTH  write-back data
- rsv_en  input  1  reserve request: marks rsv_addr busy (instruction issued, result pending)
- rsv_addr  input  ADDR_W  register being reserved
- raddr_a  input  ADDR_W  read port A index
- rdata_a  output  WIDTH  read port A data
- busy_a  output  1  register at raddr_a has a pending write
- raddr_b  input  ADDR_W  read port B index
- rdata_b  output  WIDTH  read port B data
- busy_b  output  1  register at raddr_b has a pending write
- busy_vec  output  2^ADDR_W  full scoreboard, bit i = register i busy

## Operation
- Storage: 2^ADDR_W registers of WIDTH bits. Writes are decoded internally from waddr; only reg[waddr] is updated when we=1.
- Reads are combinational: rdata_x = reg[raddr_x] and busy_x = busy[raddr_x]. No read enable is needed.
- Scoreboard, per register i on each rising edge:
  - set when rsv_en && rsv_addr==i
  - cleared when we && waddr==i
  - simultaneous set and clear on the same i: set wins, busy stays 1. The new reservation belongs to a younger instruction.
  - reserving an already-busy register keeps it at 1. There is no counting.
- Write to a non-busy register is legal. Data updates and busy stays 0.
- ZERO_REG=1: writes and reserves to index 0 are discarded. rdata_x=0 and busy_x=0 for raddr_x=0, and busy_vec[0]=0 at all times.
- ZERO_REG=0: index 0 behaves like any other register.

## Timing
- Reset (reset=0, any time, independent of clk): all registers = 0, busy_vec = 0, so rdata_a/b = 0 and busy_a/b = 0 immediately. State is held until reset=1.
  - A write or reserve coinciding with a reset assertion is lost.
  - The first edge after release operates normally.
- Write latency: wdata is visible at rdata_x the cycle after the write edge. Same-cycle behaviour is covered under Configuration.
- Scoreboard latency: busy is set, or cleared, as seen at busy_x, one edge after rsv_en, or we.
- Depth wrap: addresses span exactly 2^ADDR_W, so no out-of-range index exists.

## Configuration
- RF_BYPASS_EN defined: write-to-read forwarding.
  - When we=1 and raddr_x==waddr (not index 0 with ZERO_REG=1), rdata_x = wdata combinationally in the same cycle.
  - In the same case busy_x = 0, unless rsv_en && rsv_addr==raddr_x in the same cycle, when busy_x = 1.
  - Registered state is unaffected.
- RF_BYPASS_EN undefined: no forwarding. Same-cycle reads return the pre-edge stored value and stored busy bit.

## Test plan
- Reset and basic write/read: assert reset=0, then release. Expect rdata_a=rdata_b=0 and busy_vec=0. Write we=1, waddr=5, wdata=0xDEADBEEF. Next cycle raddr_a=5 gives rdata_a=0xDEADBEEF, and raddr_b=6 gives rdata_b=0.
- Zero register (ZERO_REG=1): write waddr=0, wdata=0xFFFFFFFF and reserve rsv_addr=0. Then expect rdata_a=0 at raddr_a=0, busy_a=0 and busy_vec[0]=0. Repeat with ZERO_REG=0: expect 0xFFFFFFFF and busy_vec[0]=1.
- Scoreboard lifecycle: rsv_en=1, rsv_addr=7 gives busy_vec[7]=1 next cycle. Write waddr=7, wdata=0x12 gives busy_vec[7]=0 and rdata=0x12 next cycle.
- Set/clear collision: register 9 busy. In one cycle drive we=1, waddr=9 together with rsv_en=1, rsv_addr=9. Expect busy_vec[9]=1 and reg[9] updated.
- Bypass:
  - With RF_BYPASS_EN: reg[3]=0x11 and busy. Drive we=1, waddr=3, wdata=0x22, raddr_a=3. Same cycle gives rdata_a=0x22 and busy_a=0.
  - Without the macro: rdata_a=0x11 and busy_a=1 that cycle; 0x22 and 0 the next.
- Async reset mid-operation: with registers 1 and 2 written and busy bits set, pulse reset=0 between clock edges. rdata and busy_vec drop to 0 before the next edge.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: binary-decoded write-back port, two async read ports, per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [ADDR_W-1:0]        raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    output logic                     busy_a,
    input  logic [ADDR_W-1:0]        raddr_b,
    output logic [WIDTH-1:0]         rdata_b,
    output logic                     busy_b,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    // One storage slot per index; a hard-wired zero slot has no flops at all.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam bit IS_ZERO = ZERO_REG && (i == 0);
        if (IS_ZERO) begin : g_zero
            assign regs[i] = '0;
            assign busy[i] = 1'b0;
        end else begin : g_store
            logic             wr_hit;
            logic             rsv_hit;
            logic [WIDTH-1:0] data_q;
            logic             busy_q;

            assign wr_hit  = we && (waddr == ADDR_W'(i));
            assign rsv_hit = rsv_en && (rsv_addr == ADDR_W'(i));

            // A reservation on the same edge as write-back belongs to a younger instruction, so set wins.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_q <= '0;
                    busy_q <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        data_q <= wdata;
                    end
                    if (rsv_hit) begin
                        busy_q <= 1'b1;
                    end else if (wr_hit) begin
                        busy_q <= 1'b0;
                    end
                end
            end

            assign regs[i] = data_q;
            assign busy[i] = busy_q;
        end
    end

    assign busy_vec = busy;

    logic zero_a;
    logic zero_b;
    assign zero_a = ZERO_REG && (raddr_a == '0);
    assign zero_b = ZERO_REG && (raddr_b == '0);

    // Read port A
    always_comb begin
        rdata_a = regs[raddr_a];
        busy_a  = busy[raddr_a];
`ifdef RF_BYPASS_EN
        if (we && (raddr_a == waddr)) begin
            rdata_a = wdata;
            busy_a  = rsv_en && (rsv_addr == raddr_a);
        end
`endif
        if (zero_a) begin
            rdata_a = '0;
            busy_a  = 1'b0;
        end
    end

    // Read port B
    always_comb begin
        rdata_b = regs[raddr_b];
        busy_b  = busy[raddr_b];
`ifdef RF_BYPASS_EN
        if (we && (raddr_b == waddr)) begin
            rdata_b = wdata;
            busy_b  = rsv_en && (rsv_addr == raddr_b);
        end
`endif
        if (zero_b) begin
            rdata_b = '0;
            busy_b  = 1'b0;
        end
    end

endmodule
